// File: rtl/if_fetch.sv
// if_fetch -- instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Owns the PC and drives the instruction SRAM request. The SRAM has a
// one-cycle read latency, so decode registers if_to_id_bus on the same edge
// that the SRAM returns the data for that PC.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous, active-high reset
//   stall[5:0]       pipeline stall vector; only stall[0] (PC/IF stop) is used
//   br_bus[32:0]     {br_e, br_addr} redirect from decode (combinational)
//   if_to_id_bus     {ce_reg, pc_reg} to decode
//   inst_sram_*      instruction SRAM request (read-only: wen/wdata are zero)
//   fetch_cnt, stall_cnt, redirect_cnt
//                    saturating performance counters, present only when the
//                    macro IF_PERF_CNT_EN is defined
//
// A redirect that arrives while fetch is stalled is parked in pend_v/pend_addr
// and applied on the first un-stalled edge. A live redirect on that edge takes
// priority and the parked one is dropped.

`ifndef StallBus
`define StallBus 6
`endif
`ifndef BR_WD
`define BR_WD 33
`endif
`ifndef IF_TO_ID_WD
`define IF_TO_ID_WD 33
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif

module if_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hbfc0_0000,
  parameter int          CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [`StallBus-1:0]    stall,
  input  logic [`BR_WD-1:0]       br_bus,
  output logic [`IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                    inst_sram_en,
  output logic [3:0]              inst_sram_wen,
  output logic [31:0]             inst_sram_addr,
  output logic [31:0]             inst_sram_wdata
`ifdef IF_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]        fetch_cnt,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        redirect_cnt
`endif
);

  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] pc_reg;
  logic        ce_reg;
  logic        pend_v;
  logic [31:0] pend_addr;
  logic [31:0] next_pc;
  logic        stop;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];
  assign stop    = (stall[0] == `Stop);

  // Live redirect beats a parked one, which beats sequential fetch.
  always_comb begin
    next_pc = pc_reg + 32'd4;
    if (br_e)        next_pc = br_addr;
    else if (pend_v) next_pc = pend_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_VECTOR - 32'd4;
      ce_reg    <= 1'b0;
      pend_v    <= 1'b0;
      pend_addr <= 32'd0;
    end else begin
      // ce rises on the first edge out of reset and then only ever holds at 1.
      ce_reg <= 1'b1;
      if (!stop) begin
        pc_reg <= next_pc;
        pend_v <= 1'b0;
      end else if (br_e) begin
        // Last redirect seen while frozen wins.
        pend_v    <= 1'b1;
        pend_addr <= br_addr;
      end
    end
  end

  // All outputs come straight from registers; br_bus never reaches a port.
  assign if_to_id_bus    = {ce_reg, pc_reg};
  assign inst_sram_en    = ce_reg;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_wdata = 32'd0;

`ifdef IF_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt    <= '0;
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (ce_reg && !stop && fetch_cnt != CNT_MAX)
        fetch_cnt <= fetch_cnt + CNT_ONE;
      if (ce_reg && stop && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_ONE;
      // Counts every edge on which the PC takes a redirect target.
      if (!stop && (br_e || pend_v) && redirect_cnt != CNT_MAX)
        redirect_cnt <= redirect_cnt + CNT_ONE;
    end
  end
`endif

endmodule
